cla_nibble_serial_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla4_core.sv | 29 ++
 rtl/cla_nibble_serial_adder.sv | 118 +++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder: sequencer states,
// nibble width, and a nibble-slice helper.
package cla_pkg;

    localparam int NIBBLE_W = 4;
    // Widest operand the slice helper can address; callers zero-extend into it.
    localparam int MAX_W    = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [NIBBLE_W-1:0] nibble(input logic [MAX_W-1:0] v,
                                                   input int unsigned     i);
        return v[NIBBLE_W*i +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/cla4_core.sv
// Pure combinational 4-bit carry-lookahead adder: generate/propagate terms with
// every carry expanded directly from cin, so no carry ripples between bits.
module cla4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit adder that streams operands LSB-nibble first through one 4-bit CLA,
// chaining the carry in a register. Define CLA_SUB_EN to add a subtract port (sub).
module cla_nibble_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state, state_n;
    logic [WIDTH-1:0]   a_reg, b_reg, acc_reg, acc_n;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_reg, cout_q, ovf_q;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [NIBBLE_W-1:0] cla_a, cla_b, cla_s;
    logic               cla_co;
    logic               b_inv, c_init;

    assign last  = (idx == IDX_W'(NIBBLES - 1));
    assign cla_a = nibble(MAX_W'(a_reg), 32'(idx));
    assign cla_b = nibble(MAX_W'(b_reg), 32'(idx));

    cla4_core u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_reg),
        .s    (cla_s),
        .cout (cla_co)
    );

    // Subtract is a + ~b + 1; the forced carry-in replaces cin.
`ifdef CLA_SUB_EN
    assign b_inv  = sub;
    assign c_init = sub | cin;
`else
    assign b_inv  = 1'b0;
    assign c_init = cin;
`endif

    // Working accumulator with the current nibble merged in; the visible sum only
    // updates once the final nibble lands, so it never shows a partial result.
    always_comb begin
        acc_n = acc_reg;
        acc_n[NIBBLE_W*idx +: NIBBLE_W] = cla_s;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_q     <= '0;
            carry_reg <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            idx       <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (in_valid) begin
                    a_reg     <= a;
                    b_reg     <= b_inv ? ~b : b;
                    carry_reg <= c_init;
                    idx       <= '0;
                end
                RUN: begin
                    acc_reg   <= acc_n;
                    carry_reg <= cla_co;
                    idx       <= idx + 1'b1;
                    if (last) begin
                        sum_q  <= acc_n;
                        cout_q <= cla_co;
                        ovf_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                  (cla_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed self-checking bench for cla_nibble_serial_adder (WIDTH=16); the
// subtract vectors are included when CLA_SUB_EN is defined.
module tb_cla_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int               n_assert = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] prev_sum;

    always #5 clk = ~clk;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, check latency and result, hold for 'hold' cycles, then drain.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input int hold);
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        chk("accept_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        for (int i = 1; i <= NIBBLES; i++) begin
            @(posedge clk); #1;
            chk("latency_out_valid", 32'(out_valid), (i == NIBBLES) ? 1 : 0);
            if (i < NIBBLES) begin
                chk("run_in_ready", 32'(in_ready), 0);
                chk("run_sum_held", 32'(sum), 32'(prev_sum));
            end
        end
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        chk("overflow", 32'(overflow), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_cout", 32'(cout), 32'(ec));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_in_ready", 32'(in_ready), 1);
        chk("drain_sum_kept", 32'(sum), 32'(es));
        prev_sum = es;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SUB_EN
        sub = 1'b0;
`endif
        prev_sum = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // Idle with in_valid low must not start anything.
        repeat (3) @(posedge clk);
        #1 chk("idle_stays", 32'(in_ready), 1);

        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        run_op(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 5);

        // Abort mid-operation with reset.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_sum", 32'(sum), 0);
        prev_sum = '0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(out_valid), 0);
        end
        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

`ifdef CLA_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op(16'h0009, 16'h0003, 1'b0, 16'h0006, 1'b1, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
